// File: rtl/letter_bitmap_draw.sv
// Text-box glyph renderer: font ROM lookup with 2-cycle latency, plus a
// frame-counted blink-in whenever the background state changes.
module letter_bitmap_draw #(
  parameter int unsigned LETTER_COUNT = 20,
  parameter logic [7:0]  TEXT_COLOR   = 8'hFF,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned BLINK_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [2:0]  bgState,
  input  logic        insideText,
  input  logic [5:0]  letter,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  output logic        drawingRequest,
  output logic [7:0]  RGBout
);

  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned CW = $clog2(BLINK_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_CYCLES);

  localparam logic [1:0] HIDDEN    = 2'd0;
  localparam logic [1:0] BLINK_ON  = 2'd1;
  localparam logic [1:0] BLINK_OFF = 2'd2;
  localparam logic [1:0] STEADY    = 2'd3;

  logic [1:0]    state, state_d;
  logic [FW-1:0] frameCnt, frame_d, frame_inc;
  logic [CW-1:0] cycleCnt, cycle_d, cycle_inc;
  logic [2:0]    prevBg;
  logic          insideText_d;
  logic          visible;
  logic [95:0]   glyph;
  logic [7:0]    glyph_row;
  logic [3:0]    row_idx;
  logic          pixel;
  logic          lit;

  logic unused_offset_bits;
  assign unused_offset_bits = ^{offsetX[10:3], offsetY[10:4]};

  assign visible = (state == BLINK_ON) || (state == STEADY);

  // Glyph rows 2..13 packed MSB-first; rows 0-1 and 14-15 are always blank.
  always_comb begin
    glyph = '0;
    if (32'(letter) < LETTER_COUNT) begin
      case (letter)
        6'd1:    glyph = 96'hFCFEC6C6_C6FEFCC0_C0C0C0C0; // P
        6'd2:    glyph = 96'hFCFEC6C6_C6FEFCD8_CCC6C6C6; // R
        6'd3:    glyph = 96'hFEFEC0C0_C0FCFCC0_C0C0FEFE; // E
        6'd4:    glyph = 96'h7CFEC0C0_C0FC7E06_0606FE7C; // S
        6'd5:    glyph = 96'h387CC6C6_C6FEFEC6_C6C6C6C6; // A
        6'd6:    glyph = 96'h7CFEC6C0_C0C0C0C0_C0C6FE7C; // C
        6'd7:    glyph = 96'hFEFE3030_30303030_30303030; // T
        6'd8:    glyph = 96'h7CFEC6C6_C6C6C6C6_C6C6FE7C; // O
        6'd9:    glyph = 96'hC6E6E6F6_F6DEDECE_CEC6C6C6; // N
        6'd10:   glyph = 96'hF8FCCEC6_C6C6C6C6_C6CEFCF8; // D
        6'd11:   glyph = 96'hC6EEFEFE_D6D6C6C6_C6C6C6C6; // M
        6'd12:   glyph = 96'hFCFC3030_30303030_3030FCFC; // I
        6'd13:   glyph = 96'hFEFE060C_0C183030_60C0FEFE; // Z
        6'd14:   glyph = 96'hFCFEC6C6_C6FCFCC6_C6C6FEFC; // B
        6'd15:   glyph = 96'hC6CCD8F0_E0E0F0D8_CCC6C6C6; // K
        6'd16:   glyph = 96'hC6C6C66C_6C383030_30303030; // Y
        6'd17:   glyph = 96'hC6C6C6C6_C6C6C6C6_C6C6FE7C; // U
        6'd18:   glyph = 96'hC6C6C6C6_C6D6D6FE_FEEEC6C6; // W
        6'd19:   glyph = 96'hC0C0C0C0_C0C0C0C0_C0C0C0FE; // L
        default: glyph = '0;
      endcase
    end
  end

  always_comb begin
    row_idx   = 4'd13 - offsetY[3:0];
    glyph_row = 8'h00;
    if (offsetY[3:0] >= 4'd2 && offsetY[3:0] <= 4'd13) begin
      glyph_row = glyph[{row_idx, 3'b000} +: 8];
    end
    pixel = glyph_row[3'd7 - offsetX[2:0]];
    lit   = insideText_d & pixel & visible;
  end

  always_comb begin
    state_d   = state;
    frame_d   = frameCnt;
    cycle_d   = cycleCnt;
    frame_inc = (frameCnt == FMAX) ? frameCnt : frameCnt + 1'b1;
    cycle_inc = (cycleCnt == CMAX) ? cycleCnt : cycleCnt + 1'b1;
    // A background change overrides a coincident frame pulse.
    if (bgState != prevBg) begin
      frame_d = '0;
      cycle_d = '0;
      state_d = (bgState == 3'd0) ? HIDDEN : BLINK_ON;
    end else if (startOfFrame) begin
      case (state)
        BLINK_ON: begin
          if (frame_inc == FMAX) begin
            state_d = BLINK_OFF;
            frame_d = '0;
          end else begin
            frame_d = frame_inc;
          end
        end
        BLINK_OFF: begin
          if (frame_inc == FMAX) begin
            frame_d = '0;
            cycle_d = cycle_inc;
            state_d = (cycle_inc == CMAX) ? STEADY : BLINK_ON;
          end else begin
            frame_d = frame_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= HIDDEN;
      frameCnt       <= '0;
      cycleCnt       <= '0;
      prevBg         <= 3'd0;
      insideText_d   <= 1'b0;
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
    end else begin
      state          <= state_d;
      frameCnt       <= frame_d;
      cycleCnt       <= cycle_d;
      prevBg         <= bgState;
      insideText_d   <= insideText;
      drawingRequest <= lit;
      RGBout         <= lit ? TEXT_COLOR : 8'h00;
    end
  end

endmodule

// File: tb/tb_letter_bitmap_draw.sv
// Scoreboard bench for letter_bitmap_draw: pixels are issued with an expected
// lit/unlit value; a monitor pops and compares when the result emerges.
module tb_letter_bitmap_draw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [2:0]  bgState = 3'd0;
  logic        insideText = 1'b0;
  logic [5:0]  letter = 6'd0;
  logic [10:0] offsetX = 11'd0;
  logic [10:0] offsetY = 11'd0;
  logic        drawingRequest;
  logic [7:0]  RGBout;

  letter_bitmap_draw #(
    .LETTER_COUNT(20),
    .TEXT_COLOR  (8'hFF),
    .BLINK_FRAMES(2),
    .BLINK_CYCLES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .bgState       (bgState),
    .insideText    (insideText),
    .letter        (letter),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .drawingRequest(drawingRequest),
    .RGBout        (RGBout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic  exp;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Tag pipeline marks the cycle at which an issued pixel's result is on the outputs.
  always @(posedge clk) begin
    v1 <= v0;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (v2) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got output with no expectation queued");
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk({e.nm, "_drawingRequest"}, {7'd0, drawingRequest}, {7'd0, e.exp});
        chk({e.nm, "_RGBout"}, RGBout, e.exp ? 8'hFF : 8'h00);
      end
    end
  end

  task automatic issue(input string nm, input logic it, input logic [5:0] l,
                       input logic [2:0] ox, input logic [3:0] oy, input logic exp);
    exp_t e;
    e.nm  = nm;
    e.exp = exp;
    @(negedge clk);
    insideText = it;
    v0 = 1'b1;
    expq.push_back(e);
    @(negedge clk);
    v0 = 1'b0;
    insideText = 1'b0;
    letter  = l;
    offsetX = {8'd0, ox};
    offsetY = {7'd0, oy};
    @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic set_bg(input logic [2:0] v);
    @(negedge clk);
    bgState = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with active inputs
    bgState = 3'd1;
    insideText = 1'b1;
    letter = 6'd19;
    offsetY = 11'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      startOfFrame = i[0];
      chk("reset_hold_dr", {7'd0, drawingRequest}, 8'h00);
      chk("reset_hold_rgb", RGBout, 8'h00);
    end
    startOfFrame = 1'b0;
    insideText = 1'b0;
    bgState = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    issue("post_reset_bg0", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    frame();
    issue("post_reset_bg0_frame", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);

    // 2: run to STEADY and probe the L glyph
    set_bg(3'd1);
    for (int i = 0; i < 8; i++) frame();
    issue("L_y5_x0", 1'b1, 6'd19, 3'd0, 4'd5, 1'b1);
    issue("L_y5_x2", 1'b1, 6'd19, 3'd2, 4'd5, 1'b0);
    issue("L_y13_x6", 1'b1, 6'd19, 3'd6, 4'd13, 1'b1);
    issue("L_y13_x7", 1'b1, 6'd19, 3'd7, 4'd13, 1'b0);
    issue("L_y12_x1", 1'b1, 6'd19, 3'd1, 4'd12, 1'b1);
    issue("L_y1_x0", 1'b1, 6'd19, 3'd0, 4'd1, 1'b0);
    issue("L_y14_x0", 1'b1, 6'd19, 3'd0, 4'd14, 1'b0);

    // 3: blank codes and insideText gating
    for (int y = 0; y < 16; y += 5) begin
      issue("code0", 1'b1, 6'd0, 3'(y), 4'(y), 1'b0);
      issue("code25", 1'b1, 6'd25, 3'(y), 4'(y), 1'b0);
    end
    issue("code20", 1'b1, 6'd20, 3'd0, 4'd5, 1'b0);
    issue("outside_text", 1'b0, 6'd19, 3'd0, 4'd5, 1'b0);

    // 4: blink sequence, one lit pixel per frame
    set_bg(3'd0);
    issue("bg_to_0_hidden", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    set_bg(3'd3);
    for (int k = 0; k < 10; k++) begin
      issue($sformatf("blink_frame%0d", k), 1'b1, 6'd19, 3'd0, 4'd5,
            (k < 2) || (k >= 4 && k < 6) || (k >= 8));
      frame();
    end

    // 5: change during BLINK_OFF coinciding with a frame pulse
    set_bg(3'd0);
    set_bg(3'd3);
    frame();
    frame();
    issue("restart_in_off", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    @(negedge clk);
    startOfFrame = 1'b1;
    bgState = 3'd4;
    @(negedge clk);
    startOfFrame = 1'b0;
    issue("restart_f0", 1'b1, 6'd19, 3'd0, 4'd5, 1'b1);
    frame();
    issue("restart_f1", 1'b1, 6'd19, 3'd0, 4'd5, 1'b1);
    frame();
    issue("restart_f2", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    frame();
    issue("restart_f3", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    frame();
    issue("restart_f4", 1'b1, 6'd19, 3'd0, 4'd5, 1'b1);
    set_bg(3'd0);
    issue("bg0_hidden", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);

    // 6: asynchronous reset while lit in BLINK_ON
    set_bg(3'd5);
    @(negedge clk);
    insideText = 1'b1;
    letter = 6'd19;
    offsetX = 11'd0;
    offsetY = 11'd5;
    repeat (3) @(negedge clk);
    chk("pre_reset_dr", {7'd0, drawingRequest}, 8'h01);
    chk("pre_reset_rgb", RGBout, 8'hFF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_dr", {7'd0, drawingRequest}, 8'h00);
    chk("async_reset_rgb", RGBout, 8'h00);
    insideText = 1'b0;
    bgState = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    issue("after_reset_hidden", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    frame();
    frame();
    issue("after_reset_frames", 1'b1, 6'd19, 3'd0, 4'd5, 1'b0);
    set_bg(3'd2);
    issue("after_reset_bg2", 1'b1, 6'd19, 3'd0, 4'd5, 1'b1);

    repeat (2) @(negedge clk);
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
